// File: rtl/cdbus_frame_mover.sv
// CSR sequencer for one cdbus core: initialises it, polls REG_INT_FLAG, streams RX frames
// out of the RX page and writes TX-stream frames into the TX page before committing them.
module cdbus_frame_mover #(
  parameter logic [7:0] INIT_SETTING  = 8'h40,
  parameter logic [7:0] INIT_FILTER   = 8'hff,
  parameter logic [7:0] INIT_IDLE_LEN = 8'd20
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       evt_rx,
  output logic       evt_tx,
  output logic       evt_err
);

  typedef enum logic [3:0] {
    S_INIT_SET, S_INIT_FILT, S_INIT_IDLE, S_IDLE, S_CLR_CD, S_CLR_RX,
    S_RX_RST, S_RX_READ, S_RX_DONE, S_TX_RST, S_TX_BYTE, S_TX_WAIT, S_TX_COMMIT
  } state_t;

  state_t     state_reg, state_next;
  logic       armed_reg;
  logic       last_rx_reg;
  logic [8:0] rx_idx_reg;
  logic [7:0] rx_len_reg;
  logic       rx_all_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       rx_last_reg;
  logic [8:0] tx_cnt_reg;
  logic       tx_ovf_reg;
  logic       rx_rd;
  logic       rx_final;

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_last  = rx_last_reg;

  // The length byte arrives at index 2, so the final-byte test there uses the live read data.
  assign rx_final = (rx_idx_reg == 9'd2) ? (csr_readdata == 8'h00)
                  : ((rx_idx_reg > 9'd2) && (rx_idx_reg == ({1'b0, rx_len_reg} + 9'd2)));

  always_comb begin
    state_next    = state_reg;
    csr_address   = 5'h00;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = 8'h00;
    tx_ready      = 1'b0;
    evt_rx        = 1'b0;
    evt_tx        = 1'b0;
    evt_err       = 1'b0;
    rx_rd         = 1'b0;
    case (state_reg)
      S_INIT_SET: if (armed_reg) begin
        csr_write = 1'b1; csr_address = 5'h01; csr_writedata = INIT_SETTING;
        state_next = S_INIT_FILT;
      end
      S_INIT_FILT: begin
        csr_write = 1'b1; csr_address = 5'h05; csr_writedata = INIT_FILTER;
        state_next = S_INIT_IDLE;
      end
      S_INIT_IDLE: begin
        csr_write = 1'b1; csr_address = 5'h02; csr_writedata = INIT_IDLE_LEN;
        state_next = S_IDLE;
      end
      S_IDLE: begin
        csr_read = 1'b1; csr_address = 5'h0a;
        if (csr_readdata[6])                       state_next = S_CLR_CD;
        else if (csr_readdata[3] | csr_readdata[2]) state_next = S_CLR_RX;
        else if (csr_readdata[1] && tx_valid)      state_next = last_rx_reg ? S_TX_RST : S_RX_RST;
        else if (csr_readdata[1])                  state_next = S_RX_RST;
        else if (tx_valid)                         state_next = S_TX_RST;
      end
      S_CLR_CD: begin
        csr_write = 1'b1; csr_address = 5'h0f; csr_writedata = 8'h08;
        evt_err = 1'b1; state_next = S_IDLE;
      end
      S_CLR_RX: begin
        csr_write = 1'b1; csr_address = 5'h0e; csr_writedata = 8'h0c;
        evt_err = 1'b1; state_next = S_IDLE;
      end
      S_RX_RST: begin
        csr_write = 1'b1; csr_address = 5'h0e; csr_writedata = 8'h01;
        state_next = S_RX_READ;
      end
      S_RX_READ: begin
        if (!rx_all_reg && (!rx_valid_reg || rx_ready)) begin
          csr_read = 1'b1; csr_address = 5'h0c; rx_rd = 1'b1;
        end
        if (rx_all_reg && rx_valid_reg && rx_ready) state_next = S_RX_DONE;
      end
      S_RX_DONE: begin
        csr_write = 1'b1; csr_address = 5'h0e; csr_writedata = 8'h02;
        evt_rx = 1'b1; state_next = S_IDLE;
      end
      S_TX_RST: begin
        csr_write = 1'b1; csr_address = 5'h0f; csr_writedata = 8'h01;
        state_next = S_TX_BYTE;
      end
      S_TX_BYTE: begin
        tx_ready = 1'b1; csr_address = 5'h0d;
        csr_write = tx_valid && !tx_cnt_reg[8];
        csr_writedata = tx_data;
        if (tx_valid && tx_last) state_next = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        csr_read = 1'b1; csr_address = 5'h0a;
        if (csr_readdata[4]) state_next = S_TX_COMMIT;
      end
      S_TX_COMMIT: begin
        csr_write = 1'b1; csr_address = 5'h0f; csr_writedata = 8'h02;
        evt_tx = 1'b1; evt_err = tx_ovf_reg; state_next = S_IDLE;
      end
      default: state_next = S_INIT_SET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_INIT_SET;
      armed_reg    <= 1'b0;
      last_rx_reg  <= 1'b0;
      rx_idx_reg   <= 9'd0;
      rx_len_reg   <= 8'd0;
      rx_all_reg   <= 1'b0;
      rx_data_reg  <= 8'd0;
      rx_valid_reg <= 1'b0;
      rx_last_reg  <= 1'b0;
      tx_cnt_reg   <= 9'd0;
      tx_ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
      if (state_next == S_RX_RST) last_rx_reg <= 1'b1;
      if (state_next == S_TX_RST) last_rx_reg <= 1'b0;
      if (state_reg == S_RX_RST) begin
        rx_idx_reg <= 9'd0;
        rx_all_reg <= 1'b0;
      end
      if (rx_rd) begin
        rx_data_reg  <= csr_readdata;
        rx_valid_reg <= 1'b1;
        rx_last_reg  <= rx_final;
        rx_idx_reg   <= rx_idx_reg + 9'd1;
        if (rx_idx_reg == 9'd2) rx_len_reg <= csr_readdata;
        if (rx_final) rx_all_reg <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_reg <= 1'b0;
        rx_last_reg  <= 1'b0;
      end
      if (state_reg == S_TX_RST) begin
        tx_cnt_reg <= 9'd0;
        tx_ovf_reg <= 1'b0;
      end else if (state_reg == S_TX_BYTE && tx_valid) begin
        // Saturate at one full page; later bytes only flag the overflow.
        if (tx_cnt_reg[8]) tx_ovf_reg <= 1'b1;
        else               tx_cnt_reg <= tx_cnt_reg + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdbus_frame_mover.sv
// Bench for cdbus_frame_mover: a behavioural cdbus CSR model plus scenario tasks
// checking init, RX streaming, TX commit, arbitration, error clearing and reset.
module tb_cdbus_frame_mover;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] csr_address;
  logic       csr_read, csr_write;
  logic [7:0] csr_readdata, csr_writedata;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last;
  logic       rx_ready = 1'b0;
  logic       evt_rx, evt_tx, evt_err;

  int compared = 0, mismatched = 0;

  logic [7:0] rx_page [0:511];
  logic [7:0] tx_page [0:511];
  logic [7:0] frm [0:511];
  int rd_ptr = 0, wr_ptr = 0, rd0c_n = 0, both_n = 0, commit_n = 0, commit_len = 0;
  int rx_set_n = 0, rx_clr_n = 0, rxe_set_n = 0, rxe_clr_n = 0, cd_set_n = 0, cd_clr_n = 0;
  logic tx_free = 1'b1;
  logic [4:0] wa_log [0:2047];
  logic [7:0] wd_log [0:2047];
  int wr_n = 0;
  logic [7:0] got_data [0:1023];
  logic       got_last [0:1023];
  int got_n = 0;
  int n_evt_rx = 0, n_evt_tx = 0, n_evt_err = 0;
  logic ord [0:63];
  int ord_n = 0;
  logic [7:0] exp_q [$];

  cdbus_frame_mover dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .evt_rx(evt_rx), .evt_tx(evt_tx), .evt_err(evt_err)
  );

  always #5 clk = ~clk;

  // Flag bits: 6 cd_error, 4 tx page free, 3 rx_error, 1 rx_pending.
  always_comb begin
    csr_readdata = 8'h00;
    if (csr_address == 5'h0a)
      csr_readdata = {1'b0, cd_set_n != cd_clr_n, 1'b0, tx_free,
                      rxe_set_n != rxe_clr_n, 1'b0, rx_set_n != rx_clr_n, 1'b0};
    else if (csr_address == 5'h0c)
      csr_readdata = rx_page[rd_ptr[8:0]];
  end

  always @(posedge clk) begin
    if (csr_read && csr_write) both_n <= both_n + 1;
    if (csr_read && csr_address == 5'h0c) begin
      rd_ptr <= rd_ptr + 1;
      rd0c_n <= rd0c_n + 1;
    end
    if (csr_write) begin
      wa_log[wr_n] <= csr_address;
      wd_log[wr_n] <= csr_writedata;
      wr_n <= wr_n + 1;
      case (csr_address)
        5'h0d: begin
          tx_page[wr_ptr[8:0]] <= csr_writedata;
          wr_ptr <= wr_ptr + 1;
        end
        5'h0e: begin
          if (csr_writedata[0]) rd_ptr <= 0;
          if (csr_writedata[1]) rx_clr_n <= rx_clr_n + 1;
          if (|csr_writedata[3:2]) rxe_clr_n <= rxe_clr_n + 1;
        end
        5'h0f: begin
          if (csr_writedata[0]) wr_ptr <= 0;
          if (csr_writedata[1]) begin
            commit_n <= commit_n + 1;
            commit_len <= wr_ptr;
          end
          if (csr_writedata[3]) cd_clr_n <= cd_clr_n + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_data[got_n] <= rx_data;
      got_last[got_n] <= rx_last;
      got_n <= got_n + 1;
    end
    if (evt_rx) begin n_evt_rx <= n_evt_rx + 1; ord[ord_n] <= 1'b0; ord_n <= ord_n + 1; end
    if (evt_tx) begin n_evt_tx <= n_evt_tx + 1; ord[ord_n] <= 1'b1; ord_n <= ord_n + 1; end
    if (evt_err) n_evt_err <= n_evt_err + 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int base;
    logic [4:0] ea [0:2];
    logic [7:0] ed [0:2];
    ea[0] = 5'h01; ea[1] = 5'h05; ea[2] = 5'h02;
    ed[0] = 8'h40; ed[1] = 8'hff; ed[2] = 8'h14;
    reset_n = 1'b0;
    repeat (3) step();
    compared++;
    if ({csr_write, csr_read, tx_ready, rx_valid, rx_last, evt_rx, evt_tx, evt_err} !== 8'h00 ||
        csr_address !== 5'h00 || csr_writedata !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got w=%b r=%b txr=%b rxv=%b rxl=%b evt=%b%b%b addr=%h wd=%h, want all zero",
               csr_write, csr_read, tx_ready, rx_valid, rx_last, evt_rx, evt_tx, evt_err, csr_address, csr_writedata);
    end
    base = wr_n;
    reset_n = 1'b1;
    repeat (12) step();
    compared++;
    if (wr_n - base != 3) begin
      mismatched++;
      $display("FAIL init_write_count: got %0d want 3", wr_n - base);
    end
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (wa_log[base+k] !== ea[k] || wd_log[base+k] !== ed[k]) begin
        mismatched++;
        $display("FAIL init_write_%0d: got (%h,%h) want (%h,%h)", k, wa_log[base+k], wd_log[base+k], ea[k], ed[k]);
      end
    end
    @(negedge clk);
    compared++;
    if (csr_read !== 1'b1 || csr_address !== 5'h0a || csr_write !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_poll: got r=%b w=%b addr=%h want r=1 w=0 addr=0a", csr_read, csr_write, csr_address);
    end
    step();
    $display("txn reset/init: %0d writes", wr_n - base);
  endtask

  task automatic test_rx(input string name, input int n, input bit toggle, input bit post);
    int base_w, base_g, base_r, base_e, cyc;
    logic [7:0] e;
    base_w = wr_n; base_g = got_n; base_r = rd0c_n; base_e = n_evt_rx; cyc = 0;
    for (int k = 0; k < n; k++) begin
      rx_page[k] = frm[k];
      exp_q.push_back(frm[k]);
    end
    rx_ready = 1'b1;
    if (post) rx_set_n++;
    while (n_evt_rx == base_e && cyc < 600) begin
      step();
      cyc++;
      if (toggle) rx_ready = ~rx_ready;
    end
    rx_ready = 1'b1;
    compared++;
    if (n_evt_rx != base_e + 1) begin
      mismatched++;
      $display("FAIL %s_evt_rx: got %0d pulses want 1", name, n_evt_rx - base_e);
    end
    compared++;
    if (got_n - base_g != n) begin
      mismatched++;
      $display("FAIL %s_byte_count: got %0d want %0d", name, got_n - base_g, n);
    end
    for (int k = 0; k < got_n - base_g && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      compared++;
      if (got_data[base_g+k] !== e || got_last[base_g+k] !== (k == n - 1)) begin
        mismatched++;
        $display("FAIL %s_byte_%0d: got %h last=%b want %h last=%b", name, k,
                 got_data[base_g+k], got_last[base_g+k], e, (k == n - 1));
      end
    end
    exp_q.delete();
    compared++;
    if (rd0c_n - base_r != n) begin
      mismatched++;
      $display("FAIL %s_page_reads: got %0d want %0d", name, rd0c_n - base_r, n);
    end
    compared++;
    if (wr_n - base_w != 2 || wa_log[base_w] !== 5'h0e || wd_log[base_w] !== 8'h01 ||
        wa_log[base_w+1] !== 5'h0e || wd_log[base_w+1] !== 8'h02) begin
      mismatched++;
      $display("FAIL %s_csr_writes: got %0d writes first (%h,%h) want (0e,01),(0e,02)", name,
               wr_n - base_w, wa_log[base_w], wd_log[base_w]);
    end
    $display("txn %s: %0d bytes in %0d cycles", name, got_n - base_g, cyc);
  endtask

  task automatic test_tx(input string name, input int n, input bit busy);
    int base_w, base_c, base_t, base_e, k, cyc, lim, n0d;
    logic acc;
    logic [7:0] e;
    base_w = wr_n; base_c = commit_n; base_t = n_evt_tx; base_e = n_evt_err;
    lim = (n > 256) ? 256 : n;
    for (int j = 0; j < lim; j++) exp_q.push_back(frm[j]);
    tx_free = !busy;
    k = 0; cyc = 0;
    tx_valid = 1'b1; tx_data = frm[0]; tx_last = (n == 1);
    while (k < n && cyc < 2000) begin
      @(negedge clk); acc = tx_ready;
      @(posedge clk); #1; cyc++;
      if (acc) begin
        k++;
        if (k < n) begin tx_data = frm[k]; tx_last = (k == n - 1); end
        else begin tx_valid = 1'b0; tx_last = 1'b0; end
      end
    end
    if (busy) begin
      repeat (20) step();
      @(negedge clk);
      compared++;
      if (commit_n != base_c || csr_read !== 1'b1 || csr_address !== 5'h0a) begin
        mismatched++;
        $display("FAIL %s_wait_poll: got commits=%0d r=%b addr=%h want commits=0 r=1 addr=0a",
                 name, commit_n - base_c, csr_read, csr_address);
      end
      step();
      tx_free = 1'b1;
    end
    cyc = 0;
    while (n_evt_tx == base_t && cyc < 200) begin step(); cyc++; end
    step();
    compared++;
    if (n_evt_tx != base_t + 1 || commit_n != base_c + 1) begin
      mismatched++;
      $display("FAIL %s_commit: got evt_tx=%0d commits=%0d want 1/1", name, n_evt_tx - base_t, commit_n - base_c);
    end
    compared++;
    if (commit_len != lim) begin
      mismatched++;
      $display("FAIL %s_commit_len: got %0d want %0d", name, commit_len, lim);
    end
    for (int j = 0; j < lim && exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      compared++;
      if (tx_page[j] !== e) begin
        mismatched++;
        $display("FAIL %s_page_byte_%0d: got %h want %h", name, j, tx_page[j], e);
      end
    end
    exp_q.delete();
    n0d = 0;
    for (int j = base_w; j < wr_n; j++) if (wa_log[j] == 5'h0d) n0d++;
    compared++;
    if (n0d != lim || wa_log[base_w] !== 5'h0f || wd_log[base_w] !== 8'h01 ||
        wa_log[wr_n-1] !== 5'h0f || wd_log[wr_n-1] !== 8'h02 || wr_n - base_w != lim + 2) begin
      mismatched++;
      $display("FAIL %s_csr_writes: got %0d data writes, %0d total, first (%h,%h) last (%h,%h) want %0d, %0d, (0f,01), (0f,02)",
               name, n0d, wr_n - base_w, wa_log[base_w], wd_log[base_w], wa_log[wr_n-1], wd_log[wr_n-1], lim, lim + 2);
    end
    compared++;
    if (n_evt_err - base_e != ((n > 256) ? 1 : 0)) begin
      mismatched++;
      $display("FAIL %s_evt_err: got %0d want %0d", name, n_evt_err - base_e, (n > 256) ? 1 : 0);
    end
    $display("txn %s: %0d bytes sent, %0d written", name, n, n0d);
  endtask

  task automatic test_arbitration();
    int base_o, base_r, base_t, k, cyc;
    logic acc;
    base_o = ord_n;
    for (int rnd = 0; rnd < 2; rnd++) begin
      base_r = n_evt_rx; base_t = n_evt_tx;
      rx_page[0] = 8'h10; rx_page[1] = 8'h20; rx_page[2] = 8'h00;
      frm[0] = 8'h05; frm[1] = 8'h00; frm[2] = 8'h00;
      rx_ready = 1'b1; rx_set_n++;
      tx_valid = 1'b1; tx_data = frm[0]; tx_last = 1'b0; k = 0; cyc = 0;
      while ((n_evt_rx == base_r || n_evt_tx == base_t) && cyc < 500) begin
        @(negedge clk); acc = tx_valid && tx_ready;
        @(posedge clk); #1; cyc++;
        if (acc) begin
          k++;
          if (k < 3) begin tx_data = frm[k]; tx_last = (k == 2); end
          else begin tx_valid = 1'b0; tx_last = 1'b0; end
        end
      end
      compared++;
      if (cyc >= 500) begin
        mismatched++;
        $display("FAIL arb_round_%0d: timed out, rx evts=%0d tx evts=%0d want 1/1", rnd,
                 n_evt_rx - base_r, n_evt_tx - base_t);
      end
      step();
    end
    compared++;
    if (ord_n - base_o != 4) begin
      mismatched++;
      $display("FAIL arb_count: got %0d services want 4", ord_n - base_o);
    end
    for (int j = 0; j < 4; j++) begin
      compared++;
      if (ord[base_o+j] !== j[0]) begin
        mismatched++;
        $display("FAIL arb_order_%0d: got %s want %s", j, ord[base_o+j] ? "TX" : "RX", j[0] ? "TX" : "RX");
      end
    end
    $display("txn arbitration: %0d services", ord_n - base_o);
  endtask

  task automatic test_error(input string name, input bit cd);
    int base_w, base_e, cyc;
    logic [7:0] ewd;
    logic [4:0] ewa;
    base_w = wr_n; base_e = n_evt_err; cyc = 0;
    ewa = cd ? 5'h0f : 5'h0e;
    ewd = cd ? 8'h08 : 8'h0c;
    if (cd) cd_set_n++; else rxe_set_n++;
    while (((cd && cd_set_n != cd_clr_n) || (!cd && rxe_set_n != rxe_clr_n)) && cyc < 50) begin
      step(); cyc++;
    end
    repeat (4) step();
    compared++;
    if (wr_n - base_w != 1 || wa_log[base_w] !== ewa || wd_log[base_w] !== ewd) begin
      mismatched++;
      $display("FAIL %s_clear_write: got %0d writes first (%h,%h) want 1 (%h,%h)", name,
               wr_n - base_w, wa_log[base_w], wd_log[base_w], ewa, ewd);
    end
    compared++;
    if (n_evt_err - base_e != 1) begin
      mismatched++;
      $display("FAIL %s_evt_err: got %0d pulses want 1", name, n_evt_err - base_e);
    end
    $display("txn %s: cleared after %0d cycles", name, cyc);
  endtask

  task automatic test_reset_mid_rx();
    int base, cyc;
    frm[0] = 8'h07; frm[1] = 8'h08; frm[2] = 8'd20;
    for (int k = 3; k < 23; k++) frm[k] = 8'(8'h30 + k);
    for (int k = 0; k < 23; k++) rx_page[k] = frm[k];
    rx_ready = 1'b0; rx_set_n++; cyc = 0;
    while (!rx_valid && cyc < 100) begin step(); cyc++; end
    compared++;
    if (rx_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL midrx_stall: got rx_valid=%b want 1", rx_valid);
    end
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    compared++;
    if (rx_valid !== 1'b0 || rx_last !== 1'b0) begin
      mismatched++;
      $display("FAIL midrx_reset_drop: got rx_valid=%b rx_last=%b want 0/0", rx_valid, rx_last);
    end
    base = wr_n;
    repeat (2) step();
    reset_n = 1'b1;
    cyc = 0;
    while (wr_n - base < 3 && cyc < 50) begin step(); cyc++; end
    compared++;
    if (wr_n - base != 3 || wa_log[base] !== 5'h01 || wd_log[base] !== 8'h40 ||
        wa_log[base+1] !== 5'h05 || wd_log[base+1] !== 8'hff || wa_log[base+2] !== 5'h02 || wd_log[base+2] !== 8'h14) begin
      mismatched++;
      $display("FAIL midrx_reinit: got %0d writes first (%h,%h) want (01,40),(05,ff),(02,14)",
               wr_n - base, wa_log[base], wd_log[base]);
    end
    test_rx("rx_after_reset", 23, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    frm[0] = 8'h01; frm[1] = 8'h02; frm[2] = 8'h03; frm[3] = 8'hAA; frm[4] = 8'hBB; frm[5] = 8'hCC;
    test_rx("rx_stream", 6, 1'b0, 1'b1);
    test_rx("rx_backpressure", 6, 1'b1, 1'b1);
    frm[0] = 8'h05; frm[1] = 8'h00; frm[2] = 8'h00;
    test_tx("tx_busy", 3, 1'b1);
    test_arbitration();
    for (int k = 0; k < 258; k++) frm[k] = 8'(k * 7 + 1);
    test_tx("tx_overflow", 258, 1'b0);
    test_error("cd_error", 1'b1);
    test_error("rx_error", 1'b0);
    test_reset_mid_rx();
    compared++;
    if (both_n != 0) begin
      mismatched++;
      $display("FAIL read_write_overlap: got %0d cycles want 0", both_n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
